// File: rtl/mux_rr_arbiter_if.sv
// Channel bundle for mux_rr_arbiter: N valid/ready producers merged into one
// registered valid/ready consumer, plus the mode/select controls.
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_sel;

    // Producer/consumer environment side
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );

    // Arbiter side
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// N-way flow-controlled channel merger with a registered output stage.
// Selection is either round-robin (mode=0) or an external index (mode=1).
module mux_rr_arbiter #(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic              clk,
    input  logic              reset,
    mux_rr_arbiter_if.slave   bus
);
    localparam int SELW = $clog2(N);
    localparam int IW   = SELW + 1;
    localparam logic [IW-1:0]   N_W      = IW'(N);
    localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

    // Round-robin search starting at 'start'; result is {found, index}.
    // The sum start+k stays below 2*N, so one conditional subtract wraps it.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0]    valid,
                                              input logic [SELW-1:0] start);
        logic [IW-1:0] res;
        logic [IW-1:0] idx;
        res = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, start} + IW'(k);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end else begin
                idx = idx;
            end
            if (!res[SELW] && valid[idx[SELW-1:0]]) begin
                res = {1'b1, idx[SELW-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Valid bit of the externally selected channel; out-of-range indices match nothing.
    function automatic logic sel_pick(input logic [N-1:0]    valid,
                                      input logic [SELW-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (idx == SELW'(i)) begin
                hit = valid[i];
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    logic               out_valid_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [SELW-1:0]    out_sel_r;
    logic [SELW-1:0]    ptr_r;

    logic               load_ok_s;
    logic [IW-1:0]      rr_res_s;
    logic               grant_vld_s;
    logic [SELW-1:0]    grant_idx_s;
    logic               xfer_s;
    logic [N-1:0]       ready_s;
    logic [WIDTH-1:0]   data_s;
    logic [SELW-1:0]    ptr_nxt_s;

    // Grant selection, handshake decode and data mux
    always_comb begin
        load_ok_s   = !out_valid_r || bus.out_ready;
        rr_res_s    = rr_pick(bus.in_valid, ptr_r);
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        ready_s     = '0;
        data_s      = '0;
        ptr_nxt_s   = '0;

        if (bus.mode) begin
            grant_vld_s = sel_pick(bus.in_valid, bus.sel);
            grant_idx_s = bus.sel;
        end else begin
            grant_vld_s = rr_res_s[SELW];
            grant_idx_s = rr_res_s[SELW-1:0];
        end

        // Ready is held low throughout reset so nothing is accepted and lost
        xfer_s = !reset && load_ok_s && grant_vld_s;

        for (int i = 0; i < N; i++) begin
            if (grant_idx_s == SELW'(i)) begin
                ready_s[i] = xfer_s;
                data_s     = bus.in_data[i*WIDTH +: WIDTH];
            end else begin
                ready_s[i] = 1'b0;
                data_s     = data_s;
            end
        end

        if (grant_idx_s == LAST_IDX) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_idx_s + SELW'(1);
        end
    end

    // Output register: load on transfer, clear valid on a drain without reload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= '0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= data_s;
            out_sel_r   <= grant_idx_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner only on mode-0 transfers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (xfer_s && !bus.mode) begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sel   = out_sel_r;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scoreboard bench for mux_rr_arbiter: a 4-channel/16-bit instance
// and a 3-channel/8-bit instance share one clock and reset.
module tb_mux_rr_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [17:0] q4[$];
    logic [9:0]  q3[$];
    logic [17:0] e4;
    logic [9:0]  e3;

    mux_rr_arbiter_if #(.WIDTH(16), .N(4)) b4 ();
    mux_rr_arbiter_if #(.WIDTH(8),  .N(3)) b3 ();

    mux_rr_arbiter #(.WIDTH(16), .N(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    mux_rr_arbiter #(.WIDTH(8),  .N(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer-side scoreboards: every accepted output word pops one expectation
    always @(negedge clk) begin
        if (!reset && b4.out_valid && b4.out_ready) begin
            checks++;
            assert (q4.size() > 0) else begin
                errors++;
                $error("FAIL q4_underflow observed=%0d expected=nonzero", q4.size());
            end
            if (q4.size() > 0) begin
                e4 = q4.pop_front();
                chk("out4_data", 32'(b4.out_data), 32'(e4[15:0]));
                chk("out4_sel",  32'(b4.out_sel),  32'(e4[17:16]));
            end
        end
        if (!reset && b3.out_valid && b3.out_ready) begin
            checks++;
            assert (q3.size() > 0) else begin
                errors++;
                $error("FAIL q3_underflow observed=%0d expected=nonzero", q3.size());
            end
            if (q3.size() > 0) begin
                e3 = q3.pop_front();
                chk("out3_data", 32'(b3.out_data), 32'(e3[7:0]));
                chk("out3_sel",  32'(b3.out_sel),  32'(e3[9:8]));
            end
        end
    end

    initial begin
        int idx;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        b4.mode = 1'b0; b4.sel = 2'd0; b4.out_ready = 1'b1;
        b4.in_data  = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
        b4.in_valid = 4'b1111;
        b3.mode = 1'b0; b3.sel = 2'd0; b3.out_ready = 1'b1;
        b3.in_data  = {8'h33, 8'h22, 8'h11};
        b3.in_valid = 3'b000;
        tick();
        tick();

        // Reset state, with every channel offering a word
        chk("rst_ready", 32'(b4.in_ready),  32'h0);
        chk("rst_valid", 32'(b4.out_valid), 32'h0);
        chk("rst_data",  32'(b4.out_data),  32'h0);
        chk("rst_sel",   32'(b4.out_sel),   32'h0);

        // Round-robin sweep with no bubbles
        reset = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            idx = k % 4;
            if (k > 0) chk("rr_nobubble", 32'(b4.out_valid), 32'h1);
            chk("rr_ready", 32'(b4.in_ready), 32'(1 << idx));
            q4.push_back({2'(idx), 16'(16'hA + idx)});
            tick();
        end

        // Reset mid-stream discards the held word at once
        chk("mid_valid_before", 32'(b4.out_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_valid", 32'(b4.out_valid), 32'h0);
        chk("mid_data",  32'(b4.out_data),  32'h0);
        chk("mid_sel",   32'(b4.out_sel),   32'h0);
        chk("mid_ready", 32'(b4.in_ready),  32'h0);
        q4.delete();
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(b4.in_ready), 32'h1);
        q4.push_back({2'd0, 16'h000A});
        tick();
        chk("post_rst_sel",  32'(b4.out_sel),  32'h0);
        chk("post_rst_data", 32'(b4.out_data), 32'hA);

        // Advance ptr to 2, then only channels 1 and 3 offer
        chk("pre_sparse_ready", 32'(b4.in_ready), 32'h2);
        q4.push_back({2'd1, 16'h000B});
        tick();
        b4.in_valid = 4'b1010;
        #1;
        for (int j = 0; j < 4; j++) begin
            idx = (j % 2 == 0) ? 3 : 1;
            chk("sparse_ready", 32'(b4.in_ready), 32'(1 << idx));
            q4.push_back({2'(idx), 16'(16'hA + idx)});
            tick();
        end

        // Backpressure: register holds channel 1's word, ptr frozen at 2
        b4.out_ready = 1'b0;
        b4.in_valid  = 4'b1111;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("bp_ready", 32'(b4.in_ready),  32'h0);
            chk("bp_valid", 32'(b4.out_valid), 32'h1);
            chk("bp_data",  32'(b4.out_data),  32'hB);
            chk("bp_sel",   32'(b4.out_sel),   32'h1);
            tick();
        end
        b4.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(b4.in_ready), 32'h4);
        q4.push_back({2'd2, 16'h000C});
        tick();
        chk("bp_reload_valid", 32'(b4.out_valid), 32'h1);
        chk("bp_reload_data",  32'(b4.out_data),  32'hC);

        // Fixed select on channel 2
        b4.mode = 1'b1;
        b4.sel  = 2'd2;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("fix_ready", 32'(b4.in_ready), 32'h4);
            q4.push_back({2'd2, 16'h000C});
            tick();
        end
        b4.in_valid = 4'b1011;
        #1;
        chk("fix_noready", 32'(b4.in_ready), 32'h0);
        tick();
        chk("fix_drain_valid", 32'(b4.out_valid), 32'h0);
        tick();
        chk("fix_idle_valid", 32'(b4.out_valid), 32'h0);

        // Back to round-robin: ptr was held at 3 through fixed mode
        b4.mode     = 1'b0;
        b4.in_valid = 4'b1111;
        #1;
        chk("mode_sw_ready", 32'(b4.in_ready), 32'h8);
        q4.push_back({2'd3, 16'h000D});
        tick();
        b4.in_valid = 4'b0000;
        tick();
        chk("final4_valid", 32'(b4.out_valid), 32'h0);

        // Three channels: round-robin wraps 2 -> 0
        b3.in_valid = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            idx = k % 3;
            chk("n3_ready", 32'(b3.in_ready), 32'(1 << idx));
            q3.push_back({2'(idx), 8'(8'h11 * (idx + 1))});
            tick();
        end

        // Illegal select index grants nothing
        b3.mode = 1'b1;
        b3.sel  = 2'd3;
        #1;
        chk("n3_ill_ready", 32'(b3.in_ready), 32'h0);
        tick();
        chk("n3_ill_valid", 32'(b3.out_valid), 32'h0);
        chk("n3_ill_ready2", 32'(b3.in_ready), 32'h0);
        tick();
        chk("n3_ill_valid2", 32'(b3.out_valid), 32'h0);

        tick();
        chk("q4_left", 32'(q4.size()), 32'h0);
        chk("q3_left", 32'(q3.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
